ip_tx_arbiter: RTL
==================

Name: ip_tx_arbiter

Overview:
- Packet-level arbiter that shares the single IP-layer TX AXI-Stream port between two requesters: source 0 (ICMP echo-reply generator) and source 1 (UDP TX).
- Grants one source at a time and holds the grant until that source's packet ends (last beat accepted).
- Drives the IP TX port through a one-stage registered output slice with full backpressure.
- Keeps per-source wrapping packet counters for debug.

Parameters:
- DATA_W, 64, tdata width.
- USER_W, 56, tuser width ({16'dlen,3'bflag,8'dtype,13'doffset,16'dID}).
- KEEP_W, 8, tkeep width (DATA_W/8).
- PRIO_EN, 0, 0 = round-robin; 1 = source 0 has fixed priority at every arbitration.

Ports:
- i_clk  in  1  single clock domain.
- i_rst  in  1  asynchronous, active-low reset.
- s0_axis_data  in  DATA_W  source 0 (ICMP) tdata.
- s0_axis_user  in  USER_W  source 0 tuser.
- s0_axis_keep  in  KEEP_W  source 0 tkeep.
- s0_axis_last  in  1  source 0 tlast.
- s0_axis_valid  in  1  source 0 tvalid.
- s0_axis_ready  out  1  source 0 tready.
- s1_axis_data, s1_axis_user, s1_axis_keep, s1_axis_last, s1_axis_valid  in  same widths  source 1 (UDP).
- s1_axis_ready  out  1  source 1 tready.
- m_axis_ip_data  out  DATA_W  to IP TX.
- m_axis_ip_user  out  USER_W  to IP TX.
- m_axis_ip_keep  out  KEEP_W  to IP TX.
- m_axis_ip_last  out  1  to IP TX.
- m_axis_ip_valid  out  1  to IP TX.
- m_axis_ip_ready  in  1  from IP TX.
- o_grant  out  2  one-hot current grant; 00 when idle.
- o_pkt_cnt0  out  16  packets forwarded from source 0; wraps.
- o_pkt_cnt1  out  16  packets forwarded from source 1; wraps.

Behaviour:
- Reset: i_rst low clears asynchronously.
  - FSM goes to IDLE; RR pointer = 0, so source 0 is next preferred.
  - All m_axis_ip_* outputs = 0; s0/s1 ready = 0; o_grant = 00; both counters = 0.
  - Reset asserted mid-packet truncates the packet; no recovery beat is emitted.
- FSM states: IDLE, GNT0, GNT1.
  - IDLE, no valid asserted: stay in IDLE.
  - IDLE, exactly one valid asserted: go to that source's GNT state next cycle.
  - IDLE, both valid asserted:
    - PRIO_EN=1: go to GNT0.
    - PRIO_EN=0: go to the GNT state of the RR-pointer source.
  - GNTn: stay until a source-n beat with last=1 is accepted, then go to IDLE next cycle.
  - On leaving GNTn: RR pointer = other source; o_pkt_cntn increments by 1 (mod 2^16).
- Ready and acceptance:
  - Define out_free = !m_axis_ip_valid || m_axis_ip_ready.
  - sN_axis_ready = (state==GNTN) && out_free, decoded from registered state (combinational).
  - A beat is accepted when sN_valid && sN_ready.
  - The ungranted source's ready is always 0; IDLE drives both readies 0.
- Output slice:
  - On an accepted beat: m_axis_ip_data/user/keep/last load the source fields; m_axis_ip_valid=1.
  - Else if m_axis_ip_ready: m_axis_ip_valid=0; data holds.
  - Output fields never change while valid=1 and ready=0.
- Latency:
  - Valid rising in IDLE → grant the next cycle → first beat on m_axis_ip at cycle +2 (ready held high).
  - Throughput inside a packet is 1 beat/cycle.
  - One idle cycle between back-to-back packets (the IDLE arbitration cycle).
- Granted source drops valid mid-packet: grant is held indefinitely; no timeout and no preemption.
- Single-beat packet (last on first beat): GNTn lasts one cycle, then IDLE.
- o_grant = {state==GNT1, state==GNT0}.
- tuser, tkeep and tdata pass unmodified; no checking of len or keep.

Test Plan:
1. Reset then single source: s0 sends a 3-beat packet, data 0x11..,0x22..,0x33.., keep FF,FF,0F, m_ready=1 → beats appear on m_axis_ip at cycles 2,3,4 after s0_valid; last on the 3rd; o_pkt_cnt0=1; o_grant returns to 00.
2. Simultaneous requests, PRIO_EN=0, both sources holding 2-beat packets continuously → output order s0,s1,s0,s1 with one bubble cycle between packets; no beat interleaving; counters equal after 4 packets (2,2).
3. PRIO_EN=1, both sources continuously valid → only source 0 packets forwarded; s1_axis_ready never asserted; o_pkt_cnt1 stays 0.
4. Backpressure: m_ready toggles 1,0,0,1 during a 4-beat s0 packet → m_axis_ip_data stable while ready=0; s0_ready low in those cycles; all 4 beats delivered in order exactly once.
5. Mid-packet stall then reset: s0 drops valid after beat 1 while s1 is valid → grant stays GNT0 and s1_ready=0; assert i_rst low → all outputs 0 immediately (asynchronously), FSM IDLE; after release, s1 is served first if s0 is idle.
6. Counter wrap: force 65536 single-beat s1 packets → o_pkt_cnt1 wraps to 0; o_pkt_cnt0 unaffected.

Source files
------------

// File: rtl/ip_tx_arbiter.sv
// ip_tx_arbiter
// Packet-level arbiter that shares the single IP-layer TX AXI-Stream port
// between source 0 (ICMP echo-reply generator) and source 1 (UDP TX).
// A source is granted for a whole packet. The grant is released only after
// that source's last beat has been accepted. The IP TX port is driven by a
// one-stage registered slice that supports full backpressure.
//
// Parameters
//   DATA_W  : tdata width
//   USER_W  : tuser width ({len, flag, type, offset, ID})
//   KEEP_W  : tkeep width (DATA_W/8)
//   PRIO_EN : 0 = round-robin between packets, 1 = source 0 always wins
//
// Ports
//   i_clk, i_rst        : clock, asynchronous active-low reset
//   s0_axis_*           : source 0 (ICMP) stream in, s0_axis_ready out
//   s1_axis_*           : source 1 (UDP) stream in, s1_axis_ready out
//   m_axis_ip_*         : stream to IP TX, m_axis_ip_ready in
//   o_grant             : one-hot current grant {GNT1, GNT0}, 00 when idle
//   o_pkt_cnt0/1        : wrapping count of packets forwarded per source
module ip_tx_arbiter #(
    parameter int DATA_W  = 64,
    parameter int USER_W  = 56,
    parameter int KEEP_W  = 8,
    parameter int PRIO_EN = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,

    input  logic [DATA_W-1:0] s0_axis_data,
    input  logic [USER_W-1:0] s0_axis_user,
    input  logic [KEEP_W-1:0] s0_axis_keep,
    input  logic              s0_axis_last,
    input  logic              s0_axis_valid,
    output logic              s0_axis_ready,

    input  logic [DATA_W-1:0] s1_axis_data,
    input  logic [USER_W-1:0] s1_axis_user,
    input  logic [KEEP_W-1:0] s1_axis_keep,
    input  logic              s1_axis_last,
    input  logic              s1_axis_valid,
    output logic              s1_axis_ready,

    output logic [DATA_W-1:0] m_axis_ip_data,
    output logic [USER_W-1:0] m_axis_ip_user,
    output logic [KEEP_W-1:0] m_axis_ip_keep,
    output logic              m_axis_ip_last,
    output logic              m_axis_ip_valid,
    input  logic              m_axis_ip_ready,

    output logic [1:0]        o_grant,
    output logic [15:0]       o_pkt_cnt0,
    output logic [15:0]       o_pkt_cnt1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t            state_q;
    logic              rr_q;      // source preferred at the next tie: 0 or 1
    logic [DATA_W-1:0] data_q;
    logic [USER_W-1:0] user_q;
    logic [KEEP_W-1:0] keep_q;
    logic              last_q;
    logic              valid_q;
    logic [15:0]       cnt0_q;
    logic [15:0]       cnt1_q;

    logic out_free;
    logic acc0;
    logic acc1;

    // The slice can take a new beat when it is empty or its beat leaves now.
    assign out_free      = !valid_q || m_axis_ip_ready;
    assign s0_axis_ready = (state_q == GNT0) && out_free;
    assign s1_axis_ready = (state_q == GNT1) && out_free;
    assign acc0          = s0_axis_valid && s0_axis_ready;
    assign acc1          = s1_axis_valid && s1_axis_ready;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            data_q  <= '0;
            user_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            cnt0_q  <= 16'd0;
            cnt1_q  <= 16'd0;
        end else begin
            // Output slice: at most one source can be accepting at a time.
            if (acc0) begin
                data_q  <= s0_axis_data;
                user_q  <= s0_axis_user;
                keep_q  <= s0_axis_keep;
                last_q  <= s0_axis_last;
                valid_q <= 1'b1;
            end else if (acc1) begin
                data_q  <= s1_axis_data;
                user_q  <= s1_axis_user;
                keep_q  <= s1_axis_keep;
                last_q  <= s1_axis_last;
                valid_q <= 1'b1;
            end else if (m_axis_ip_ready) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (s0_axis_valid && s1_axis_valid) begin
                        state_q <= ((PRIO_EN != 0) || !rr_q) ? GNT0 : GNT1;
                    end else if (s0_axis_valid) begin
                        state_q <= GNT0;
                    end else if (s1_axis_valid) begin
                        state_q <= GNT1;
                    end
                end
                GNT0: begin
                    // Grant is held, even across source stalls, until last.
                    if (acc0 && s0_axis_last) begin
                        state_q <= IDLE;
                        rr_q    <= 1'b1;
                        cnt0_q  <= cnt0_q + 16'd1;
                    end
                end
                GNT1: begin
                    if (acc1 && s1_axis_last) begin
                        state_q <= IDLE;
                        rr_q    <= 1'b0;
                        cnt1_q  <= cnt1_q + 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_axis_ip_data  = data_q;
    assign m_axis_ip_user  = user_q;
    assign m_axis_ip_keep  = keep_q;
    assign m_axis_ip_last  = last_q;
    assign m_axis_ip_valid = valid_q;
    assign o_grant         = {state_q == GNT1, state_q == GNT0};
    assign o_pkt_cnt0      = cnt0_q;
    assign o_pkt_cnt1      = cnt1_q;

endmodule
